// File: rtl/uart_receiver.sv
// UART receive block: 16x-oversampled start/data/stop framing of an asynchronous rx line,
// presenting each good byte through a valid/acknowledge handshake with frame-error and overrun flags.
module uart_receiver #(
   parameter int DATA_W  = 8,
   parameter int OS_RATE = 16
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              rst,
   input  logic              os_tick,
   input  logic              rx,
   input  logic              rx_ack,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   localparam int TICK_W = $clog2(OS_RATE);
   localparam int CNT_W  = $clog2(DATA_W + 1);

   localparam logic [TICK_W-1:0] HALF_M1 = TICK_W'(OS_RATE / 2 - 1);
   localparam logic [TICK_W-1:0] FULL_M1 = TICK_W'(OS_RATE - 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state;
   logic [1:0]          sync_q;
   logic                rx_s;
   logic [TICK_W-1:0]   tick_cnt;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shift_reg;

   assign rx_s      = sync_q[1];
   assign state_dbg = state;

   // Handshake: rx_valid stays high from the good-stop edge until the clk edge that sees
   // rx_ack high; a byte completing on that same edge still wins and leaves rx_valid set.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= IDLE;
         sync_q    <= 2'b11;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else if (rst) begin
         state     <= IDLE;
         sync_q    <= 2'b11;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx};
         frame_err <= 1'b0;
         if (rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
         if (os_tick) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state    <= START;
                     tick_cnt <= '0;
                     busy     <= 1'b1;
                  end
               end
               START: begin
                  if (tick_cnt == HALF_M1) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     if (!rx_s) begin
                        state <= DATA;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               DATA: begin
                  if (tick_cnt == FULL_M1) begin
                     shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
                     bit_cnt   <= bit_cnt + CNT_W'(1);
                     tick_cnt  <= '0;
                     if (bit_cnt == LAST_BIT) state <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               STOP: begin
                  if (tick_cnt == FULL_M1) begin
                     tick_cnt <= '0;
                     state    <= IDLE;
                     busy     <= 1'b0;
                     if (rx_s) begin
                        rx_data  <= shift_reg;
                        rx_valid <= 1'b1;
                        // Overwriting an unread byte; an ack on this edge consumes the old one instead.
                        if (rx_valid && !rx_ack) overrun <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end else if (state != IDLE && state != START && state != DATA && state != STOP) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good frame, glitch, framing error, overrun, ack collision,
// asynchronous reset mid-frame and soft reset, with hand-computed expected values.
module tb_uart_receiver;

   localparam int DATA_W   = 8;
   localparam int OS_RATE  = 16;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLK  = OS_RATE * TICK_DIV;
   localparam int STOP_LOW = (BIT_CLK * 3) / 4;

   logic              clk = 1'b0;
   logic              arst = 1'b1;
   logic              rst = 1'b0;
   logic              os_tick = 1'b0;
   logic              rx = 1'b1;
   logic              rx_ack = 1'b0;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              frame_err;
   logic              overrun;
   logic              busy;
   logic [1:0]        state_dbg;

   int n_vec = 0;
   int n_bad = 0;
   int fe_cnt = 0;

   uart_receiver #(.DATA_W(DATA_W), .OS_RATE(OS_RATE)) dut (
      .clk       (clk),
      .arst      (arst),
      .rst       (rst),
      .os_tick   (os_tick),
      .rx        (rx),
      .rx_ack    (rx_ack),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // os_tick every TICK_DIV clocks, changed just after the rising edge
   initial begin
      int div = 0;
      forever begin
         @(posedge clk);
         #2;
         os_tick = (div == TICK_DIV - 1);
         div = (div == TICK_DIV - 1) ? 0 : div + 1;
      end
   end

   // counts clk cycles with frame_err high
   always @(negedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // driver: start bit, DATA_W bits LSB-first, stop bit (a bad stop is low for 3/4 bit)
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_ok);
      @(negedge clk);
      rx = 1'b0;
      wait_clk(BIT_CLK - 1);
      for (int i = 0; i < DATA_W; i++) begin
         @(negedge clk);
         rx = d[i];
         wait_clk(BIT_CLK - 1);
      end
      @(negedge clk);
      rx = stop_ok;
      if (stop_ok) begin
         wait_clk(BIT_CLK - 1);
      end else begin
         wait_clk(STOP_LOW - 1);
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic idle_line(input int bits);
      @(negedge clk);
      rx = 1'b1;
      wait_clk(bits * BIT_CLK);
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      wait_clk(2);
   endtask

   // raises rx_ack for exactly the clk that registers the stop-sample tick
   task automatic ack_on_stop_sample();
      int guard = 0;
      int n = 0;
      while (state_dbg != 2'd3 && guard < 4 * BIT_CLK * (DATA_W + 2)) begin
         @(negedge clk);
         guard++;
      end
      check_eq("stop_reached", {30'd0, state_dbg}, 32'd3);
      guard = 0;
      while (n < OS_RATE && guard < 2 * BIT_CLK) begin
         @(negedge clk);
         guard++;
         if (os_tick) n++;
      end
      check_eq("stop_tick_count", n, OS_RATE);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   initial begin
      // reset state
      wait_clk(4);
      check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
      check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_state", {30'd0, state_dbg}, 32'd0);
      arst = 1'b0;
      idle_line(1);

      // framing error: 0x3C with a low stop bit
      send_frame(8'h3C, 1'b0);
      idle_line(2);
      check_eq("ferr_pulses", fe_cnt, 32'd1);
      check_eq("ferr_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("ferr_rx_data", {24'd0, rx_data}, 32'h00);
      check_eq("ferr_busy", {31'd0, busy}, 32'd0);

      // good frame 0xA5
      send_frame(8'hA5, 1'b1);
      wait_clk(8);
      check_eq("good_rx_data", {24'd0, rx_data}, 32'hA5);
      check_eq("good_rx_valid", {31'd0, rx_valid}, 32'd1);
      check_eq("good_frame_err", fe_cnt, 32'd1);
      check_eq("good_overrun", {31'd0, overrun}, 32'd0);
      check_eq("good_busy", {31'd0, busy}, 32'd0);
      pulse_ack();
      check_eq("ack_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("ack_rx_data_held", {24'd0, rx_data}, 32'hA5);
      pulse_ack();
      check_eq("ack_idle_valid", {31'd0, rx_valid}, 32'd0);
      idle_line(1);

      // glitch: low for 4 ticks
      @(negedge clk);
      rx = 1'b0;
      wait_clk(12);
      check_eq("glitch_busy_mid", {31'd0, busy}, 32'd1);
      wait_clk(4);
      rx = 1'b1;
      wait_clk(44);
      check_eq("glitch_busy_end", {31'd0, busy}, 32'd0);
      check_eq("glitch_state", {30'd0, state_dbg}, 32'd0);
      check_eq("glitch_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("glitch_frame_err", fe_cnt, 32'd1);
      idle_line(1);

      // overrun: 0x11 then 0x22, no ack
      send_frame(8'h11, 1'b1);
      idle_line(1);
      check_eq("ovr_first_overrun", {31'd0, overrun}, 32'd0);
      send_frame(8'h22, 1'b1);
      wait_clk(8);
      check_eq("ovr_rx_data", {24'd0, rx_data}, 32'h22);
      check_eq("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
      check_eq("ovr_overrun", {31'd0, overrun}, 32'd1);
      pulse_ack();
      check_eq("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("ovr_ack_overrun", {31'd0, overrun}, 32'd0);
      idle_line(1);

      // ack collides with completion of 0x22 while 0x11 is pending
      send_frame(8'h11, 1'b1);
      idle_line(1);
      fork
         send_frame(8'h22, 1'b1);
         ack_on_stop_sample();
      join
      wait_clk(4);
      check_eq("coll_rx_data", {24'd0, rx_data}, 32'h22);
      check_eq("coll_rx_valid", {31'd0, rx_valid}, 32'd1);
      check_eq("coll_overrun", {31'd0, overrun}, 32'd0);
      idle_line(1);

      // asynchronous reset during data bit 3 of 0xFF
      fork
         send_frame(8'hFF, 1'b1);
         begin
            wait_clk(BIT_CLK * 4 + BIT_CLK / 2);
            arst = 1'b1;
            @(negedge clk);
            check_eq("arst_rx_data", {24'd0, rx_data}, 32'h00);
            check_eq("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
            check_eq("arst_frame_err", {31'd0, frame_err}, 32'd0);
            check_eq("arst_overrun", {31'd0, overrun}, 32'd0);
            check_eq("arst_busy", {31'd0, busy}, 32'd0);
            wait_clk(2);
            arst = 1'b0;
            wait_clk(4);
            check_eq("arst_release_busy", {31'd0, busy}, 32'd0);
         end
      join
      idle_line(2);
      check_eq("post_arst_valid", {31'd0, rx_valid}, 32'd0);
      send_frame(8'h5A, 1'b1);
      wait_clk(8);
      check_eq("fresh_rx_data", {24'd0, rx_data}, 32'h5A);
      check_eq("fresh_rx_valid", {31'd0, rx_valid}, 32'd1);
      check_eq("fresh_frame_err", fe_cnt, 32'd1);

      // synchronous soft reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("srst_rx_data", {24'd0, rx_data}, 32'h00);
      check_eq("srst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("srst_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // overall time bound
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
